// File: rtl/better_neighbor_scan.sv
// Scans the neighbor qValue table and records the indices of neighbors whose qValue is
// strictly below our own, then writes the resulting count back to memory.
module better_neighbor_scan #(
    parameter logic [15:0] NEI_CNT_ADDR = 16'h068A,
    parameter logic [15:0] QVAL_BASE    = 16'h01C8,
    parameter logic [15:0] BN_BASE      = 16'h0668,
    parameter logic [15:0] BN_CNT_ADDR  = 16'h068C,
    parameter int unsigned MAX_NEI      = 64,
    parameter int unsigned MAX_BN       = 16
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        start,
    input  logic [15:0] my_qvalue,
    output logic [15:0] mem_addr,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [4:0]  better_count,
    output logic        overflow
);

    localparam logic [6:0]  MaxNei   = 7'(MAX_NEI);
    localparam logic [4:0]  MaxBn    = 5'(MAX_BN);
    localparam logic [15:0] MaxNei16 = 16'(MAX_NEI);

    typedef enum logic [2:0] {
        StIdle,
        StRdCnt,
        StRdQ,
        StWrBn,
        StWrCnt,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] idx_q, idx_d;
    logic [6:0] nei_q, nei_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] bc_q, bc_d;
    logic       ovf_q, ovf_d;

    logic [6:0] idx_next;
    logic [6:0] nei_clamped;
    logic       last_nei;
    logic       is_better;
    logic       has_room;

    assign idx_next    = idx_q + 7'd1;
    assign last_nei    = (idx_next == nei_q);
    assign nei_clamped = (mem_rdata > MaxNei16) ? MaxNei : mem_rdata[6:0];
    assign is_better   = (mem_rdata < my_qvalue);
    assign has_room    = (cnt_q < MaxBn);

    // State register
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            idx_q <= '0;
            nei_q <= '0;
            cnt_q <= '0;
            bc_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            nei_q <= nei_d;
            cnt_q <= cnt_d;
            bc_q  <= bc_d;
            ovf_q <= ovf_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nei_d   = nei_q;
        cnt_d   = cnt_q;
        bc_d    = bc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRdCnt;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StRdCnt: begin
                nei_d   = nei_clamped;
                state_d = (nei_clamped == 7'd0) ? StWrCnt : StRdQ;
            end
            StRdQ: begin
                if (is_better && has_room) begin
                    state_d = StWrBn;
                end else begin
                    // A better neighbor with a full table is dropped and flagged.
                    if (is_better) begin
                        ovf_d = 1'b1;
                    end
                    idx_d   = idx_next;
                    state_d = last_nei ? StWrCnt : StRdQ;
                end
            end
            StWrBn: begin
                cnt_d   = cnt_q + 5'd1;
                idx_d   = idx_next;
                state_d = last_nei ? StWrCnt : StRdQ;
            end
            StWrCnt: begin
                bc_d    = cnt_q;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        mem_wr_en = 1'b0;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StRdCnt: begin
                mem_addr = NEI_CNT_ADDR;
            end
            StRdQ: begin
                mem_addr = QVAL_BASE + {8'h00, idx_q, 1'b0};
            end
            StWrBn: begin
                mem_addr  = BN_BASE + {10'h000, cnt_q, 1'b0};
                mem_wdata = {8'h00, 1'b0, idx_q};
                mem_wr_en = 1'b1;
            end
            StWrCnt: begin
                mem_addr  = BN_CNT_ADDR;
                mem_wdata = {11'h000, cnt_q};
                mem_wr_en = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign better_count = bc_q;
    assign overflow     = ovf_q;

endmodule
